// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for a request/grant memory port. It is backed by a
// word-addressed 64-bit RAM with byte-strobe writes, answers out-of-range
// addresses with an error response, inserts wait states before each grant,
// and latches a sticky flag when the initiator alters a stalled request.
//
// Optional feature (compile-time macro MEM_RESPONDER_RANDOM_STALL_EN):
//   defined   - wait states come from a 16-bit Fibonacci LFSR,
//               S = LFSR[7:0] mod (MAX_STALL+1); FIXED_STALL is unused.
//   undefined - every request waits FIXED_STALL cycles; no LFSR exists.
//
// Ports:
//   g_clk         in   1   global clock
//   g_reset       in   1   synchronous active-high reset
//   mem_req       in   1   request from initiator
//   mem_addr      in  64   request byte address
//   mem_wen       in   1   1 = write, 0 = read
//   mem_strb      in   8   write byte strobes, bit i enables wdata[8i+7:8i]
//   mem_wdata     in  64   write data
//   mem_gnt       out  1   request accepted (registered, one cycle)
//   mem_err       out  1   response error, valid in the response cycle
//   mem_rdata     out 64   read data, valid in the response cycle
//   mem_rsp       out  1   response-cycle marker (one-cycle pulse)
//   protocol_err  out  1   sticky: initiator changed its request while stalled
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
    parameter int          DEPTH_LOG2  = 10,
    parameter int          FIXED_STALL = 0,
    parameter int          MAX_STALL   = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        mem_req,
    input  logic [63:0] mem_addr,
    input  logic        mem_wen,
    input  logic [7:0]  mem_strb,
    input  logic [63:0] mem_wdata,
    output logic        mem_gnt,
    output logic        mem_err,
    output logic [63:0] mem_rdata,
    output logic        mem_rsp,
    output logic        protocol_err
);

    localparam int          DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [63:0] OFFSET_MASK = (64'd1 << (DEPTH_LOG2 + 3)) - 64'd1;
    localparam int          STALL_MAX   = (FIXED_STALL > MAX_STALL) ? FIXED_STALL : MAX_STALL;
    localparam int          CNT_W       = $clog2(STALL_MAX + 2);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      stall_next;
    logic [CNT_W-1:0]      stall_load;

    logic [63:0]           snap_addr;
    logic                  snap_wen;
    logic [7:0]            snap_strb;
    logic [63:0]           snap_wdata;

    logic                  accept;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  req_changed;

    logic [63:0]           ram [DEPTH];

`ifdef MEM_RESPONDER_RANDOM_STALL_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    // Taps 16,14,13,11 counted from 1 at the LSB end, shifting towards the MSB.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    assign stall_load = CNT_W'(32'(lfsr[7:0]) % (MAX_STALL + 1));
`else
    assign stall_load = CNT_W'(FIXED_STALL);
`endif

    // A new request is taken from IDLE, or straight out of RESP for back-to-back.
    assign accept   = ((state == ST_IDLE) || (state == ST_RESP)) && mem_req;
    assign in_range = (snap_addr & ~OFFSET_MASK) == BASE_ADDR;
    assign word_idx = snap_addr[DEPTH_LOG2+2:3];

    // Only a held request may be compared; dropping req in WAIT is an abandon.
    assign req_changed = ((state == ST_WAIT) || (state == ST_GRANT)) && mem_req &&
                         ({mem_addr, mem_wen, mem_strb, mem_wdata} !=
                          {snap_addr, snap_wen, snap_strb, snap_wdata});

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs -- no latches.
        state_next = state;
        stall_next = stall_cnt;
        case (state)
            ST_IDLE, ST_RESP: begin
                if (mem_req) begin
                    if (stall_load == '0) begin
                        state_next = ST_GRANT;
                    end else begin
                        state_next = ST_WAIT;
                        stall_next = stall_load;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!mem_req) begin
                    state_next = ST_IDLE;
                    stall_next = '0;
                end else if (stall_cnt == CNT_W'(1)) begin
                    state_next = ST_GRANT;
                    stall_next = '0;
                end else begin
                    stall_next = stall_cnt - CNT_W'(1);
                end
            end
            ST_GRANT: state_next = ST_RESP;
            default:  state_next = ST_IDLE;
        endcase
    end

    // NOTE: registers update with <= so every flop samples pre-edge values.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state        <= ST_IDLE;
            stall_cnt    <= '0;
            mem_gnt      <= 1'b0;
            mem_err      <= 1'b0;
            mem_rdata    <= '0;
            mem_rsp      <= 1'b0;
            protocol_err <= 1'b0;
            snap_addr    <= '0;
            snap_wen     <= 1'b0;
            snap_strb    <= '0;
            snap_wdata   <= '0;
        end else begin
            state     <= state_next;
            stall_cnt <= stall_next;
            mem_gnt   <= (state_next == ST_GRANT);
            mem_rsp   <= (state == ST_GRANT);
            mem_err   <= (state == ST_GRANT) && !in_range;

            // rdata is only refreshed by a granted read or an error; it holds otherwise.
            if (state == ST_GRANT) begin
                if (!in_range) begin
                    mem_rdata <= '0;
                end else if (!snap_wen) begin
                    mem_rdata <= ram[word_idx];
                end
            end

            if (accept) begin
                snap_addr  <= mem_addr;
                snap_wen   <= mem_wen;
                snap_strb  <= mem_strb;
                snap_wdata <= mem_wdata;
            end

            if (req_changed) begin
                protocol_err <= 1'b1;
            end
        end
    end

    // NOTE: the RAM array has no reset; only the write enable is gated by reset.
    always_ff @(posedge g_clk) begin
        if (!g_reset && (state == ST_GRANT) && snap_wen && in_range) begin
            for (int i = 0; i < 8; i++) begin
                if (snap_strb[i]) begin
                    ram[word_idx][8*i +: 8] <= snap_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Three responders share one clock and reset: instance 0 with no wait states,
// instance 1 with three, instance 2 with two (all random when the stall macro
// is defined). A reference model keeps the expected RAM image per instance
// as an associative array of words and derives range, error and data results
// directly from the address arithmetic. A monitor checks that every grant is
// followed by exactly one response pulse.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    localparam logic [63:0] BASE      = 64'h0000_0000_8000_0000;
    localparam logic [63:0] RAM_BYTES = 64'd8192;
    localparam int          MAX_STALL = 3;
    localparam int          N_DUT     = 3;

    logic        g_clk;
    logic        g_reset;
    logic        req     [N_DUT];
    logic [63:0] addr_s  [N_DUT];
    logic        wen_s   [N_DUT];
    logic [7:0]  strb_s  [N_DUT];
    logic [63:0] wdata_s [N_DUT];
    logic        gnt     [N_DUT];
    logic        err     [N_DUT];
    logic [63:0] rdata   [N_DUT];
    logic        rsp     [N_DUT];
    logic        perr    [N_DUT];

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 0;

    logic [63:0] mm [int];

    for (genvar i = 0; i < N_DUT; i++) begin : g_dut
        mem_responder #(
            .FIXED_STALL((i == 0) ? 0 : ((i == 1) ? 3 : 2)),
            .MAX_STALL  (MAX_STALL)
        ) u_dut (
            .g_clk       (g_clk),
            .g_reset     (g_reset),
            .mem_req     (req[i]),
            .mem_addr    (addr_s[i]),
            .mem_wen     (wen_s[i]),
            .mem_strb    (strb_s[i]),
            .mem_wdata   (wdata_s[i]),
            .mem_gnt     (gnt[i]),
            .mem_err     (err[i]),
            .mem_rdata   (rdata[i]),
            .mem_rsp     (rsp[i]),
            .protocol_err(perr[i])
        );
    end

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int fixed_stall_of(input int d);
        case (d)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic bit in_rng(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + RAM_BYTES);
    endfunction

    function automatic int key_of(input int d, input logic [63:0] a);
        logic [63:0] off;
        off = (a - BASE) >> 3;
        return d * 65536 + int'(off[15:0]);
    endfunction

    // One full transaction: present request, wait for grant, check the response.
    task automatic txn(input int d, input logic w, input logic [63:0] a, input logic [7:0] s,
                       input logic [63:0] wd, input bit hold, input string tag,
                       output logic [63:0] rd_out, output logic err_out);
        int          stall;
        int          k;
        logic [63:0] merged;
        req[d] = 1'b1; wen_s[d] = w; addr_s[d] = a; strb_s[d] = s; wdata_s[d] = wd;
        rd_out = 'x; err_out = 1'bx;
        stall = 0;
        @(negedge g_clk);
        while (gnt[d] !== 1'b1 && stall < 64) begin
            stall++;
            @(negedge g_clk);
        end
        check({tag, " gnt"}, 64'(gnt[d]), 64'd1);
        if (gnt[d] === 1'b1) begin
`ifdef MEM_RESPONDER_RANDOM_STALL_EN
            check({tag, " stall<=max"}, 64'(stall <= MAX_STALL), 64'd1);
`else
            check({tag, " stall"}, 64'(stall), 64'(fixed_stall_of(d)));
`endif
            @(negedge g_clk);
            rd_out = rdata[d]; err_out = err[d];
            check({tag, " rsp"}, 64'(rsp[d]), 64'd1);
            check({tag, " err"}, 64'(err[d]), 64'(!in_rng(a)));
            k = key_of(d, a);
            if (!in_rng(a)) begin
                check({tag, " rdata oor"}, rdata[d], 64'd0);
            end else if (!w) begin
                if (mm.exists(k)) check({tag, " rdata"}, rdata[d], mm[k]);
            end else if (mm.exists(k) || s == 8'hFF) begin
                merged = mm.exists(k) ? mm[k] : 64'd0;
                for (int b = 0; b < 8; b++) if (s[b]) merged[8*b +: 8] = wd[8*b +: 8];
                mm[k] = merged;
            end
        end
        if (!hold) req[d] = 1'b0;
    endtask

    // Response pulse must follow each grant by exactly one cycle (unless reset hit).
    logic prev_gnt [N_DUT];
    logic rst_edge;
    initial for (int d = 0; d < N_DUT; d++) prev_gnt[d] = 1'b0;
    always @(posedge g_clk) begin
        rst_edge = g_reset;
        #1;
        for (int d = 0; d < N_DUT; d++) begin
            if (mon_en && (gnt[d] === 1'b1 || rsp[d] === 1'b1 || prev_gnt[d])) begin
                check("mon rsp after gnt", 64'(rsp[d]), 64'(prev_gnt[d] && !rst_edge));
                if (prev_gnt[d]) check("mon gnt single", 64'(gnt[d]), 64'd0);
            end
            prev_gnt[d] = (gnt[d] === 1'b1);
        end
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        logic [63:0] a;
        logic [63:0] old;
        int          cyc;
        int          n_txn;

        g_reset = 1'b1;
        for (int d = 0; d < N_DUT; d++) begin
            req[d] = 1'b0; addr_s[d] = '0; wen_s[d] = 1'b0; strb_s[d] = '0; wdata_s[d] = '0;
        end
        repeat (3) @(negedge g_clk);
        g_reset = 1'b0;
        @(negedge g_clk);
        for (int d = 0; d < N_DUT; d++) begin
            check("reset gnt",   64'(gnt[d]),  64'd0);
            check("reset rsp",   64'(rsp[d]),  64'd0);
            check("reset err",   64'(err[d]),  64'd0);
            check("reset rdata", rdata[d],     64'd0);
            check("reset perr",  64'(perr[d]), 64'd0);
        end
        mon_en = 1;

        // ---- directed data tests on instance 0 ----
        txn(0, 1'b1, 64'h8000_0010, 8'hFF, 64'h1122334455667788, 0, "wr full", rd, er);
        txn(0, 1'b0, 64'h8000_0010, 8'hFF, 64'h0, 0, "rd full", rd, er);
        check("rd full value", rd, 64'h1122334455667788);
        txn(0, 1'b1, 64'h8000_0010, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 0, "wr part", rd, er);
        txn(0, 1'b0, 64'h8000_0010, 8'h00, 64'h0, 0, "rd part", rd, er);
        check("rd part value", rd, 64'h11223344_BBBBBBBB);
        txn(0, 1'b0, 64'h0000_2000, 8'h00, 64'h0, 0, "rd oor", rd, er);
        check("rd oor err", 64'(er), 64'd1);
        check("rd oor data", rd, 64'd0);
        txn(0, 1'b0, 64'h8000_0017, 8'h00, 64'h0, 0, "rd low bits", rd, er);
        check("rd low bits err", 64'(er), 64'd0);
        check("rd low bits value", rd, 64'h11223344_BBBBBBBB);
        txn(0, 1'b1, 64'h8000_0010, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 0, "wr strb0", rd, er);
        check("wr strb0 err", 64'(er), 64'd0);
        txn(0, 1'b0, 64'h8000_0010, 8'h00, 64'h0, 0, "rd strb0", rd, er);
        check("rd strb0 value", rd, 64'h11223344_BBBBBBBB);
        txn(0, 1'b1, 64'h8000_0000, 8'hFF, 64'hCAFE_F00D_1234_5678, 0, "wr w0", rd, er);
        txn(0, 1'b1, 64'h8000_2000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 0, "wr alias", rd, er);
        check("wr alias err", 64'(er), 64'd1);
        txn(0, 1'b0, 64'h1_8000_0000, 8'h00, 64'h0, 0, "rd hi oor", rd, er);
        check("rd hi oor err", 64'(er), 64'd1);
        txn(0, 1'b0, 64'h8000_0000, 8'h00, 64'h0, 0, "rd w0", rd, er);
        check("rd w0 value", rd, 64'hCAFE_F00D_1234_5678);

`ifndef MEM_RESPONDER_RANDOM_STALL_EN
        // ---- fixed stall of 3 and abandoned request on instance 1 ----
        txn(1, 1'b1, 64'h8000_0010, 8'hFF, 64'h0BAD_CAFE_0000_0001, 0, "s3 wr", rd, er);
        req[1] = 1'b1; wen_s[1] = 1'b0; addr_s[1] = 64'h8000_0010; strb_s[1] = '0; wdata_s[1] = '0;
        repeat (2) begin
            @(negedge g_clk);
            check("abandon early gnt", 64'(gnt[1]), 64'd0);
        end
        req[1] = 1'b0;
        repeat (5) begin
            @(negedge g_clk);
            check("abandon gnt", 64'(gnt[1]), 64'd0);
            check("abandon rsp", 64'(rsp[1]), 64'd0);
        end
        check("abandon perr", 64'(perr[1]), 64'd0);
        txn(1, 1'b0, 64'h8000_0010, 8'h00, 64'h0, 0, "s3 rd after abandon", rd, er);
        check("s3 rd value", rd, 64'h0BAD_CAFE_0000_0001);

        // ---- protocol violation on instance 2 ----
        txn(2, 1'b1, 64'h8000_0000, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, "p wr0", rd, er);
        txn(2, 1'b1, 64'h8000_0008, 8'hFF, 64'hFEDC_BA98_7654_3210, 0, "p wr1", rd, er);
        check("perr clean", 64'(perr[2]), 64'd0);
        req[2] = 1'b1; wen_s[2] = 1'b0; addr_s[2] = 64'h8000_0000; strb_s[2] = '0; wdata_s[2] = '0;
        @(negedge g_clk);
        check("p stalled", 64'(gnt[2]), 64'd0);
        addr_s[2] = 64'h8000_0008;
        cyc = 0;
        while (gnt[2] !== 1'b1 && cyc < 64) begin
            cyc++;
            @(negedge g_clk);
        end
        check("p gnt", 64'(gnt[2]), 64'd1);
        @(negedge g_clk);
        check("p rsp", 64'(rsp[2]), 64'd1);
        check("p snapshot data", rdata[2], 64'h0123_4567_89AB_CDEF);
        check("p perr set", 64'(perr[2]), 64'd1);
        req[2] = 1'b0;
        repeat (4) @(negedge g_clk);
        check("p perr sticky", 64'(perr[2]), 64'd1);
`endif

        // ---- randomized back-to-back traffic ----
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) begin
                txn(d, 1'b1, BASE + 64'(w) * 8, 8'hFF, {$urandom, $urandom}, 1, "init", rd, er);
            end
            n_txn = (d == 0) ? 700 : 300;
            for (int i = 0; i < n_txn; i++) begin
                if (d == 0 && i == n_txn / 2) begin
                    // Write interrupted by reset during its grant cycle.
                    old = mm[key_of(0, BASE + 64'd40)];
                    req[0] = 1'b1; wen_s[0] = 1'b1; addr_s[0] = BASE + 64'd40;
                    strb_s[0] = 8'hFF; wdata_s[0] = ~old;
                    cyc = 0;
                    @(negedge g_clk);
                    while (gnt[0] !== 1'b1 && cyc < 64) begin
                        cyc++;
                        @(negedge g_clk);
                    end
                    check("abort gnt", 64'(gnt[0]), 64'd1);
                    g_reset = 1'b1;
                    req[0] = 1'b0;
                    @(negedge g_clk);
                    g_reset = 1'b0;
                    for (int r = 0; r < N_DUT; r++) begin
                        check("midreset gnt",   64'(gnt[r]),  64'd0);
                        check("midreset rsp",   64'(rsp[r]),  64'd0);
                        check("midreset rdata", rdata[r],     64'd0);
                        check("midreset perr",  64'(perr[r]), 64'd0);
                    end
                    txn(0, 1'b0, BASE + 64'd40, 8'h00, 64'h0, 1, "abort rd", rd, er);
                    check("abort not written", rd, old);
                end
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       a = {$urandom, $urandom};
                        1:       a = BASE + RAM_BYTES + 64'($urandom_range(0, 255));
                        default: a = BASE - 64'd8 + 64'($urandom_range(0, 7));
                    endcase
                end else begin
                    a = BASE + 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(0, 7));
                end
                txn(d, ($urandom_range(0, 3) == 0), a, 8'($urandom), {$urandom, $urandom},
                    1, "rand", rd, er);
            end
            req[d] = 1'b0;
            repeat (4) @(negedge g_clk);
            check("rand perr", 64'(perr[d]), 64'd0);
        end

        repeat (4) @(negedge g_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
